// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM state encoding,
// pipeline event channel indices and a saturating increment helper.
package perf_pkg;

    typedef enum logic [1:0] {
        ST_WARMUP   = 2'd0,
        ST_RUN      = 2'd1,
        ST_FINISHED = 2'd2
    } perf_state_e;

    localparam int EV_RETIRED = 0;
    localparam int EV_STALL   = 1;
    localparam int EV_BUBBLE  = 2;
    localparam int EV_FLUSH   = 3;
    localparam int EV_RAW     = 4;
    localparam int EV_FWD1    = 5;
    localparam int EV_FWD2    = 6;
    localparam int EV_BRANCH  = 7;

    // Callers zero-extend their counter into 64 bits and pass their own ceiling.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] limit);
        return (value >= limit) ? limit : value + 64'd1;
    endfunction

endpackage

// File: rtl/perf_finish_detect.sv
// Program-finish detector: flags when the fetch stream has gone quiet, i.e.
// instr_if has been zero or pc_if has not moved for STUCK_LIMIT cycles in a row.
// Both run lengths only advance while 'active' is high and are held at zero otherwise.
module perf_finish_detect
    import perf_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STUCK_LIMIT = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic [PC_W-1:0] pc_if,
    input  logic [31:0]     instr_if,
    output logic            finish_hit
);

    localparam int LIM_W = (STUCK_LIMIT > 0) ? $clog2(STUCK_LIMIT + 1) : 1;
    localparam logic [LIM_W-1:0] LIMIT = LIM_W'(STUCK_LIMIT);

    logic [PC_W-1:0]  pc_prev_q, pc_prev_d;
    logic [LIM_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [LIM_W-1:0] stuck_cnt_q, stuck_cnt_d;

    // Run lengths include the current cycle, so the hit fires in the cycle the limit is reached.
    always_comb begin
        pc_prev_d   = pc_if;
        zero_cnt_d  = '0;
        stuck_cnt_d = '0;
        if (active) begin
            if (instr_if == 32'd0) begin
                zero_cnt_d = LIM_W'(sat_inc(64'(zero_cnt_q), 64'(LIMIT)));
            end
            if (pc_if == pc_prev_q) begin
                stuck_cnt_d = LIM_W'(sat_inc(64'(stuck_cnt_q), 64'(LIMIT)));
            end
        end
        finish_hit = active && ((zero_cnt_d >= LIMIT) || (stuck_cnt_d >= LIMIT));
    end

    // Detector state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_prev_q   <= '0;
            zero_cnt_q  <= '0;
            stuck_cnt_q <= '0;
        end else begin
            pc_prev_q   <= pc_prev_d;
            zero_cnt_q  <= zero_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// N-channel saturating event counter bank with warm-up gating, sticky overflow
// flags, an atomic shadow snapshot with registered indexed readout, and optional
// program-finish detection enabled by the PERF_FINISH_DETECT_EN macro.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int WARMUP      = 100,
    parameter int STUCK_LIMIT = 10,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              perf_enable,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [PC_W-1:0]   pc_if,
    input  logic [31:0]       instr_if,
    input  logic              clear,
    input  logic              snap_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [NUM_CH-1:0] ovf,
    output logic [1:0]        state_o,
    output logic              program_finished
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    perf_state_e       state_q, state_d;
    logic [31:0]       warm_cnt_q, warm_cnt_d;
    logic              fin_snap_q, fin_snap_d;
    logic [CNT_W-1:0]  ch_q [NUM_CH];
    logic [CNT_W-1:0]  ch_d [NUM_CH];
    logic [CNT_W-1:0]  shadow_q [NUM_CH];
    logic [CNT_W-1:0]  shadow_d [NUM_CH];
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CNT_W-1:0]  rd_data_q, rd_data_d;
    logic              in_run;
    logic              count_en;
    logic              finish_hit;

    assign in_run   = (state_q == ST_RUN);
    assign count_en = in_run && perf_enable;

`ifdef PERF_FINISH_DETECT_EN
    perf_finish_detect #(
        .PC_W       (PC_W),
        .STUCK_LIMIT(STUCK_LIMIT)
    ) u_finish_detect (
        .clk       (clk),
        .rst       (rst),
        .active    (in_run),
        .pc_if     (pc_if),
        .instr_if  (instr_if),
        .finish_hit(finish_hit)
    );
`else
    logic unused_fetch;
    assign unused_fetch = ^{pc_if, instr_if};
    assign finish_hit   = 1'b0;
`endif

    // Phase sequencing: WARMUP counts out its cycles, RUN waits for a finish hit, FINISHED is terminal.
    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        fin_snap_d = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                if (warm_cnt_q + 32'd1 >= 32'(WARMUP)) begin
                    state_d = ST_RUN;
                end else begin
                    warm_cnt_d = warm_cnt_q + 32'd1;
                end
            end
            ST_RUN: begin
                if (finish_hit) begin
                    state_d    = ST_FINISHED;
                    fin_snap_d = 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Live counters: saturate at all-ones, an event lost at the ceiling sets ovf; clear overrides counting.
    always_comb begin
        cycle_d = cycle_q;
        ovf_d   = ovf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i] = ch_q[i];
        end
        if (count_en) begin
            cycle_d = CNT_W'(sat_inc(64'(cycle_q), 64'(CNT_MAX)));
            for (int i = 0; i < NUM_CH; i++) begin
                if (event_in[i]) begin
                    if (ch_q[i] == CNT_MAX) begin
                        ovf_d[i] = 1'b1;
                    end
                    ch_d[i] = CNT_W'(sat_inc(64'(ch_q[i]), 64'(CNT_MAX)));
                end
            end
        end
        if (clear) begin
            cycle_d = '0;
            ovf_d   = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_d[i] = '0;
            end
        end
    end

    // Shadow copy takes the pre-update counters; the finish snapshot lands one cycle after entry, once counters are frozen.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = (snap_req || fin_snap_q) ? ch_q[i] : shadow_q[i];
        end
        rd_data_d = '0;
        if (32'(rd_sel) < 32'(NUM_CH)) begin
            rd_data_d = shadow_q[rd_sel];
        end
    end

    // All architectural state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_WARMUP;
            warm_cnt_q <= '0;
            fin_snap_q <= 1'b0;
            cycle_q    <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i]     <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            fin_snap_q <= fin_snap_d;
            cycle_q    <= cycle_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ch_q[i]     <= ch_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    assign rd_data          = rd_data_q;
    assign cycle_count      = cycle_q;
    assign ovf              = ovf_q;
    assign state_o          = state_q;
    assign program_finished = (state_q == ST_FINISHED);

endmodule
